// File: rtl/shift_seq_if.sv
`default_nettype none
// ============================================================================
//  shift_seq_if
//  Bundles the request/response handshake of shift_seq together with the
//  single-position shifter link it drives.
//
//  Request  : start, op, data_in, amount          (control decode -> seq)
//  Response : busy, done, result, flag_c, flag_z  (seq -> ALU result mux)
//  Shifter  : sh_a, sh_sel (seq -> shifter), sh_out (shifter -> seq)
//
//  modport slave  : the sequencer side
//  modport master : the control decode / shifter side
//  Revision: 1.0  initial release
// ============================================================================
interface shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] sh_a;
  logic [1:0]       sh_sel;
  logic [WIDTH-1:0] sh_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;

  modport slave (
    input  start, op, data_in, amount, sh_out,
    output sh_a, sh_sel, busy, done, result, flag_c, flag_z
  );

  modport master (
    output start, op, data_in, amount, sh_out,
    input  sh_a, sh_sel, busy, done, result, flag_c, flag_z
  );
endinterface
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  shift_seq
//  Multi-cycle sequencer that performs shifts/rotates by 0..2^AMT_W-1
//  positions using an external one-position shifter. The shifter output is
//  fed back into its input once per clock until the count is exhausted.
//
//  Ports:
//    clk    - system clock, rising edge
//    rst_n  - asynchronous active-low reset
//    bus    - shift_seq_if.slave: start/op/data_in/amount request,
//             busy/done/result/flag_c/flag_z response,
//             sh_a/sh_sel to the shifter, sh_out back from it
//  Op encoding (same as shifter select): 00 SLL, 01 SRL, 10 ROL, 11 ROR
//  Revision: 1.0  initial release
// ============================================================================
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [1:0]       op_r, op_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] result_r, result_n;
  logic             flag_c_r, flag_c_n;
  logic             flag_z_r, flag_z_n;
  logic             out_bit;

  // Bit that leaves acc on this pass: left-going ops (SLL/ROL) lose the MSB,
  // right-going ops (SRL/ROR) lose the LSB. op[0] distinguishes direction.
  assign out_bit = op_r[0] ? acc[0] : acc[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      op_r     <= '0;
      cnt      <= '0;
      result_r <= '0;
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      op_r     <= op_n;
      cnt      <= cnt_n;
      result_r <= result_n;
      flag_c_r <= flag_c_n;
      flag_z_r <= flag_z_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    op_n     = op_r;
    cnt_n    = cnt;
    result_n = result_r;
    flag_c_n = flag_c_r;
    flag_z_n = flag_z_r;

    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_n = bus.data_in;
          op_n  = bus.op;
          cnt_n = bus.amount;
          if (bus.amount == '0) begin
            // Nothing to shift: publish the operand directly.
            result_n = bus.data_in;
            flag_c_n = 1'b0;
            flag_z_n = (bus.data_in == '0);
            state_n  = DONE;
          end else begin
            state_n = SHIFT;
          end
        end
      end

      SHIFT: begin
        acc_n = bus.sh_out;
        cnt_n = cnt - 1'b1;
        // cnt is never 0 here (amount 0 bypasses SHIFT), so it cannot wrap.
        // Flags are only published on the final pass so they hold their
        // previous values for the whole operation.
        if (cnt == AMT_W'(1)) begin
          result_n = bus.sh_out;
          flag_c_n = out_bit;
          flag_z_n = (bus.sh_out == '0);
          state_n  = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status decoded from registered state only.
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.sh_a   = acc;
  assign bus.sh_sel = op_r;
  assign bus.result = result_r;
  assign bus.flag_c = flag_c_r;
  assign bus.flag_z = flag_z_r;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  tb_shift_seq
//  Self-checking bench for shift_seq. Models the external one-position
//  shifter, runs directed and random operations and compares against a
//  whole-amount arithmetic reference of each shift/rotate.
//  Revision: 1.0  initial release
// ============================================================================
module tb_shift_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] prev_res;
  logic       prev_c;
  logic       prev_z;

  always #5 clk = ~clk;

  shift_seq_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // External one-position shifter
  always_comb begin
    case (bus.sh_sel)
      2'b00:   bus.sh_out = {bus.sh_a[6:0], 1'b0};
      2'b01:   bus.sh_out = {1'b0, bus.sh_a[7:1]};
      2'b10:   bus.sh_out = {bus.sh_a[6:0], bus.sh_a[7]};
      default: bus.sh_out = {bus.sh_a[0], bus.sh_a[7:1]};
    endcase
  end

  // Reference: whole-amount shift/rotate and the last bit moved out.
  function automatic logic [7:0] ref_val(input logic [7:0] d, input logic [1:0] o, input int n);
    int v;
    v = int'(d);
    case (o)
      2'b00:   return 8'((v << n) & 255);
      2'b01:   return 8'(v >> n);
      2'b10:   return 8'(((v << n) | (v >> (8 - n))) & 255);
      default: return 8'(((v >> n) | (v << (8 - n))) & 255);
    endcase
  endfunction

  function automatic logic ref_c(input logic [7:0] d, input logic [1:0] o, input int n);
    int v;
    v = int'(d);
    if (n == 0) return 1'b0;
    if (o[0] == 1'b0) return 1'((v >> (8 - n)) & 1);
    return 1'((v >> (n - 1)) & 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"},   32'(bus.busy),   32'd0);
    check({tag, " done"},   32'(bus.done),   32'd0);
    check({tag, " result"}, 32'(bus.result), 32'd0);
    check({tag, " flag_c"}, 32'(bus.flag_c), 32'd0);
    check({tag, " flag_z"}, 32'(bus.flag_z), 32'd0);
    check({tag, " sh_a"},   32'(bus.sh_a),   32'd0);
    check({tag, " sh_sel"}, 32'(bus.sh_sel), 32'd0);
  endtask

  // One complete operation, checked cycle by cycle from acceptance to IDLE.
  // With noise set, start is pulsed with junk operands while busy.
  task automatic run_op(input logic [7:0] d, input logic [1:0] o, input int n, input bit noise);
    logic [7:0] er;
    logic       ec;
    er = ref_val(d, o, n);
    ec = ref_c(d, o, n);
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = d; bus.op = o; bus.amount = 3'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.data_in = 8'($urandom); bus.op = 2'($urandom); bus.amount = 3'($urandom);
    for (int k = 1; k <= n + 1; k++) begin
      check("busy", 32'(bus.busy), 32'd1);
      check("done", 32'(bus.done), (k == n + 1) ? 32'd1 : 32'd0);
      check("sh_sel", 32'(bus.sh_sel), 32'(o));
      check("sh_a", 32'(bus.sh_a), 32'(ref_val(d, o, k - 1)));
      if (k <= n) begin
        check("result held", 32'(bus.result), 32'(prev_res));
        check("flag_c held", 32'(bus.flag_c), 32'(prev_c));
        check("flag_z held", 32'(bus.flag_z), 32'(prev_z));
      end else begin
        check("result", 32'(bus.result), 32'(er));
        check("flag_c", 32'(bus.flag_c), 32'(ec));
        check("flag_z", 32'(bus.flag_z), (er == 8'd0) ? 32'd1 : 32'd0);
      end
      if (noise) begin
        bus.start = 1'($urandom);
        bus.data_in = 8'($urandom); bus.op = 2'($urandom); bus.amount = 3'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    prev_res = er; prev_c = ec; prev_z = (er == 8'd0);
    check("idle busy", 32'(bus.busy), 32'd0);
    check("idle done", 32'(bus.done), 32'd0);
    check("idle result", 32'(bus.result), 32'(er));
  endtask

  initial begin
    bus.start = 1'b0; bus.data_in = '0; bus.op = '0; bus.amount = '0;
    prev_res = '0; prev_c = 1'b0; prev_z = 1'b0;

    // Reset state
    @(negedge clk);
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(8'h0A, 2'b00, 3, 1'b0);   // 0x50
    run_op(8'hF6, 2'b01, 2, 1'b0);   // 0x3D, c=1
    run_op(8'h0A, 2'b11, 4, 1'b0);   // 0xA0, c=1
    run_op(8'h81, 2'b10, 1, 1'b0);   // 0x03, c=1
    run_op(8'hF6, 2'b10, 0, 1'b0);   // passthrough
    run_op(8'h80, 2'b00, 1, 1'b0);   // 0x00, z=1, c=1
    run_op(8'h0A, 2'b00, 7, 1'b1);   // max count, start ignored while busy
    run_op(8'h00, 2'b11, 0, 1'b0);   // zero operand, amount 0

    // Random operations
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 2'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
    end

    // Reset mid-operation: 0xF6 SRL 5, reset two cycles after acceptance
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = 8'hF6; bus.op = 2'b01; bus.amount = 3'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      check("abort no done", 32'(bus.done), 32'd0);
    end
    prev_res = '0; prev_c = 1'b0; prev_z = 1'b0;
    run_op(8'h0A, 2'b00, 1, 1'b0);   // 0x14

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
